// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, writes the register file, runs the store handshake, flushes on mispredict.
// Optional RVFI retirement trace is built when COMMIT_RVFI_EN is defined.
module commit_unit #(
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 head_valid,
    input  logic [ROB_IDX_W-1:0] head_rob_idx,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_value,
    input  logic                 head_is_store,
    input  logic                 head_is_branch,
    input  logic                 head_br_taken,
    input  logic                 head_pred_taken,
    input  logic [31:0]          head_target,
    input  logic [31:0]          head_pc,
    output logic                 deq,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [31:0]          rf_data,
    output logic [ROB_IDX_W-1:0] rf_rob_idx,
    output logic                 st_req,
    output logic [ROB_IDX_W-1:0] st_rob_idx,
    input  logic                 st_ack,
    output logic                 flush,
    output logic [31:0]          redirect_pc,
    output logic [63:0]          instret,
`ifdef COMMIT_RVFI_EN
    output logic                 rvfi_valid,
    output logic [63:0]          rvfi_order,
    output logic [31:0]          rvfi_pc_rdata,
    output logic [31:0]          rvfi_pc_wdata,
    output logic [4:0]           rvfi_rd_addr,
    output logic [31:0]          rvfi_rd_wdata,
`endif
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        COMMIT  = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   mispredict;
    logic   retire_alu;
    logic   retire_st;

    assign mispredict = head_is_branch && (head_br_taken != head_pred_taken);
    assign state_dbg  = state;

    // Store handshake: st_req is a level held from the cycle after the store
    // reaches the head until the cycle st_ack is seen high; st_ack is only
    // sampled in ST_WAIT and completes the store (and dequeues it) that cycle.
    always_comb begin
        state_nxt  = state;
        deq        = 1'b0;
        retire_alu = 1'b0;
        retire_st  = 1'b0;
        case (state)
            COMMIT: begin
                if (head_valid) begin
                    if (head_is_store) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        deq        = 1'b1;
                        retire_alu = 1'b1;
                        if (mispredict) state_nxt = FLUSH;
                    end
                end
            end
            ST_WAIT: begin
                if (st_ack) begin
                    deq       = 1'b1;
                    retire_st = 1'b1;
                    state_nxt = COMMIT;
                end
            end
            FLUSH: state_nxt = COMMIT;
            default: state_nxt = COMMIT;
        endcase
        // No dequeue may escape while the block is held in reset.
        if (!rst) begin
            deq        = 1'b0;
            retire_alu = 1'b0;
            retire_st  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= COMMIT;
            rf_we       <= 1'b0;
            rf_rd       <= '0;
            rf_data     <= '0;
            rf_rob_idx  <= '0;
            st_req      <= 1'b0;
            st_rob_idx  <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            instret     <= '0;
        end else begin
            state <= state_nxt;
            rf_we <= 1'b0;
            flush <= 1'b0;
            if (retire_alu) begin
                rf_we      <= (head_rd != 5'd0);
                rf_rd      <= head_rd;
                rf_data    <= head_value;
                rf_rob_idx <= head_rob_idx;
                instret    <= instret + 64'd1;
                if (mispredict) begin
                    flush       <= 1'b1;
                    redirect_pc <= head_target;
                end
            end
            if (state == COMMIT && head_valid && head_is_store) begin
                st_req     <= 1'b1;
                st_rob_idx <= head_rob_idx;
            end
            if (retire_st) begin
                st_req  <= 1'b0;
                instret <= instret + 64'd1;
            end
        end
    end

`ifdef COMMIT_RVFI_EN
    logic retire_any;
    assign retire_any = retire_alu || retire_st;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rvfi_valid    <= 1'b0;
            rvfi_order    <= '0;
            rvfi_pc_rdata <= '0;
            rvfi_pc_wdata <= '0;
            rvfi_rd_addr  <= '0;
            rvfi_rd_wdata <= '0;
        end else begin
            rvfi_valid <= 1'b0;
            if (retire_any) begin
                rvfi_valid    <= 1'b1;
                rvfi_order    <= instret;
                rvfi_pc_rdata <= head_pc;
                rvfi_pc_wdata <= head_is_branch ? head_target : head_pc + 32'd4;
                // Stores and x0 destinations report no register write.
                if (head_is_store || head_rd == 5'd0) begin
                    rvfi_rd_addr  <= 5'd0;
                    rvfi_rd_wdata <= 32'd0;
                end else begin
                    rvfi_rd_addr  <= head_rd;
                    rvfi_rd_wdata <= head_value;
                end
            end
        end
    end
`else
    logic unused_head_pc;
    assign unused_head_pc = ^head_pc;
`endif

endmodule
